isqrt_seq: RTL and testbench

Sequential integer square-root unit, the inverse of the distance-squaring multiplier. It takes an unsigned sum of squared differences (squared Euclidean distance) and returns floor(sqrt(x)) and the remainder, so the kNN datapath can report true distances. It uses the restoring digit-by-digit method at one root bit per cycle, with valid/ready handshakes on both sides. It sits between the distance accumulator and the result/sort stage.

---
 rtl/isqrt_seq.sv | 195 +++++++++++++++++++
 tb/tb_isqrt_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
// Sequential integer square root (restoring, one root bit per cycle).
// Returns root = floor(sqrt(in_rad)) and rem = in_rad - root*root.
//
// Parameters:
//   Bit        root width (>= 2); radicand is 2*Bit bits, remainder Bit+1 bits
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   radicand present on in_rad
//   in_ready   unit can accept a radicand (IDLE only)
//   in_rad     unsigned radicand, sampled only on the accept cycle
//   out_valid  root/rem valid (DONE)
//   out_ready  downstream accepts the result
//   root       floor(sqrt(radicand)), registered
//   rem        radicand - root*root, registered, range 0..2*root
//   busy       high in CALC or DONE
// -----------------------------------------------------------------------------
module isqrt_seq #(
    parameter int Bit = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*Bit-1:0] in_rad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Bit-1:0]   root,
    output logic [Bit:0]     rem,
    output logic             busy
);

    localparam int CW = (Bit > 1) ? $clog2(Bit) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(Bit - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*Bit-1:0]   rad_q, rad_d;
    logic [Bit+1:0]     r_q, r_d;
    logic [Bit-1:0]     q_q, q_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [Bit-1:0]     root_q, root_d;
    logic [Bit:0]       rem_q, rem_d;

    // Single-iteration results, consumed by the datapath process in CALC
    logic [Bit+1:0]     r_shift;
    logic [Bit+1:0]     trial;
    logic [Bit+1:0]     r_iter;
    logic [Bit-1:0]     q_iter;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rad_q   <= {(2*Bit){1'b0}};
            r_q     <= {(Bit+2){1'b0}};
            q_q     <= {Bit{1'b0}};
            cnt_q   <= CNT_ZERO;
            root_q  <= {Bit{1'b0}};
            rem_q   <= {(Bit+1){1'b0}};
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                // No overlap: a new radicand waits until the state is back in IDLE
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One restoring iteration: bring down the next two radicand bits and try
    // subtracting (4q+1); the subtraction succeeding sets the next root bit
    always_comb begin
        r_shift = {r_q[Bit-1:0], rad_q[2*Bit-1:2*Bit-2]};
        trial   = {q_q, 2'b01};
        if (r_shift >= trial) begin
            r_iter = r_shift - trial;
            q_iter = {q_q[Bit-2:0], 1'b1};
        end else begin
            r_iter = r_shift;
            q_iter = {q_q[Bit-2:0], 1'b0};
        end
    end

    // Datapath load / iterate / result capture
    always_comb begin
        rad_d  = rad_q;
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        root_d = root_q;
        rem_d  = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d = in_rad;
                    r_d   = {(Bit+2){1'b0}};
                    q_d   = {Bit{1'b0}};
                    cnt_d = CNT_LAST;
                end else begin
                    rad_d = rad_q;
                end
            end
            CALC: begin
                rad_d = {rad_q[2*Bit-3:0], 2'b00};
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q - CNT_ONE;
                // The result registers change only on the final iteration edge,
                // so they hold through DONE and the following IDLE
                if (cnt_q == CNT_ZERO) begin
                    root_d = q_iter;
                    rem_d  = r_iter[Bit:0];
                end else begin
                    root_d = root_q;
                end
            end
            DONE: begin
                rad_d = rad_q;
            end
            default: begin
                rad_d = rad_q;
            end
        endcase
    end

    // Handshake/status outputs decoded from registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            CALC: begin
                busy = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign root = root_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
// Directed bench for isqrt_seq (Bit = 8): hand-computed roots/remainders,
// accept-to-result latency, backpressure hold, mid-operation reset and a
// strided sweep checked against root^2 + rem == x and rem <= 2*root.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

    localparam int Bit = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*Bit-1:0] in_rad;
    logic             out_valid;
    logic             out_ready;
    logic [Bit-1:0]   root;
    logic [Bit:0]     rem;
    logic             busy;

    int n_cmp;
    int n_err;

    isqrt_seq #(.Bit(Bit)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rad    (in_rad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem),
        .busy      (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a radicand at a negedge; returns after the accept edge
    task automatic start(input logic [2*Bit-1:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_rad   = v;
        @(posedge clk);
    endtask

    // Counts negedges after the accept edge until out_valid; 8 means the
    // result appeared just after edge t+8. Scrambles in_rad during CALC.
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_rad   = 16'hA5C3;
        while (out_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            in_rad = in_rad + 16'd4097;
            n++;
        end
    endtask

    // Full transaction with out_ready high, checks latency/root/rem and the return to IDLE
    task automatic run_one(input string tag, input logic [2*Bit-1:0] v,
                           input logic [Bit-1:0] er, input logic [Bit:0] em);
        int n;
        start(v);
        wait_done(n);
        chk({tag, "_lat"}, n, 32'd8);
        chk({tag, "_root"}, {24'd0, root}, {24'd0, er});
        chk({tag, "_rem"}, {23'd0, rem}, {23'd0, em});
        @(negedge clk);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int  n;
        bit  ok;
        bit  bp_ok;
        bit  stale;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rad    = 16'd0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_root", {24'd0, root}, 32'd0);
        chk("rst_rem", {23'd0, rem}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 100 -> 10 r0, with status checks at the result point
        start(16'd100);
        wait_done(n);
        chk("r100_lat", n, 32'd8);
        chk("r100_root", {24'd0, root}, 32'd10);
        chk("r100_rem", {23'd0, rem}, 32'd0);
        chk("r100_busy", {31'd0, busy}, 32'd1);
        chk("r100_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("r100_ready_back", {31'd0, in_ready}, 32'd1);
        chk("r100_valid_drop", {31'd0, out_valid}, 32'd0);

        run_one("r99", 16'd99, 8'd9, 9'd18);
        run_one("r0", 16'd0, 8'd0, 9'd0);
        run_one("r1", 16'd1, 8'd1, 9'd0);
        run_one("rmax", 16'd65535, 8'd255, 9'd510);
        // Result holds through IDLE
        chk("hold_idle_root", {24'd0, root}, 32'd255);
        chk("hold_idle_rem", {23'd0, rem}, 32'd510);

        // Reset at CALC iteration 4 of 1000: accept, three iterations, then rst
        start(16'd1000);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_root", {24'd0, root}, 32'd0);
        chk("mid_rst_rem", {23'd0, rem}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        chk("no_stale_result", {31'd0, stale}, 32'd0);
        run_one("r1000", 16'd1000, 8'd31, 9'd39);

        // Backpressure: 50000 held for 20 cycles while 4 is offered
        out_ready = 1'b0;
        start(16'd50000);
        wait_done(n);
        chk("bp_lat", n, 32'd8);
        bp_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_rad   = 16'd4;
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                root !== 8'd223 || rem !== 9'd271) bp_ok = 1'b0;
        end
        chk("bp_hold", {31'd0, bp_ok}, 32'd1);
        chk("bp_root", {24'd0, root}, 32'd223);
        chk("bp_rem", {23'd0, rem}, 32'd271);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
        // in_valid is still high with 4: accepted on the next edge
        @(posedge clk);
        wait_done(n);
        chk("r4_lat", n, 32'd8);
        chk("r4_root", {24'd0, root}, 32'd2);
        chk("r4_rem", {23'd0, rem}, 32'd0);
        @(negedge clk);

        // Strided sweep including both ends, checked by the defining identity
        ok = 1'b1;
        for (int v = 0; v < 65536; v += 61) begin
            for (int k = 0; k < 2; k++) begin
                int x;
                x = (k == 0) ? v : 65535 - v;
                start(x[15:0]);
                wait_done(n);
                if (n != 8 || int'(root) * int'(root) + int'(rem) != x ||
                    int'(rem) > 2 * int'(root)) begin
                    ok = 1'b0;
                    $display("sweep x=%0d root=%0d rem=%0d lat=%0d", x, root, rem, n);
                end
                @(negedge clk);
            end
        end
        chk("sweep", {31'd0, ok}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
